// File: rtl/serial_pkg.sv
// Shared definitions for the framed serial link (transmitter now, receiver later).
package serial_pkg;

  // Frame sequencing states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

  // Line levels for the idle line, the start bit and the stop bit.
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit period timer: counts DIV clocks per serial bit and flags the last one.
module bit_timer
  import serial_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  output logic tick,
  output logic tick_next
);

  localparam int            CW   = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: held at zero while cleared, wraps on the last cycle of a bit.
  // tick_next lets the owner register a flag that lines up with tick.
  always_comb begin
    tick = (cnt_q == LAST);
    if (clr) begin
      cnt_d = {CW{1'b0}};
    end else if (tick) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    tick_next = (cnt_d == LAST);
  end

  // Period counter register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Parallel-in serial-out framed transmitter: start bit, WIDTH data bits LSB
// first, stop bit, every bit held DIV clocks. All outputs are registered and
// are computed from the next state so they change on the same edge as it.
module serial_tx
  import serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DATA,
  input  logic             LOAD,
  output logic             READY,
  output logic             SOUT,
  output logic             BUSY,
  output logic             DONE
);

  localparam int            BW       = cnt_width(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  tx_state_e        state_q;
  tx_state_e        state_d;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic [BW-1:0]    bit_idx_q;
  logic [BW-1:0]    bit_idx_d;
  logic             sout_q;
  logic             sout_d;
  logic             ready_q;
  logic             ready_d;
  logic             busy_q;
  logic             busy_d;
  logic             done_q;
  logic             done_d;
  logic             tick;
  logic             tick_next;
  logic             timer_clr;

  // The timer sits at zero while idle so a frame always starts on a full period.
  assign timer_clr = (state_q == S_IDLE);

  bit_timer #(
    .DIV (DIV)
  ) u_bit_timer (
    .CLK       (CLK),
    .RST       (RST),
    .clr       (timer_clr),
    .tick      (tick),
    .tick_next (tick_next)
  );

  // Frame sequencing, shifting and bit indexing.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    case (state_q)
      S_IDLE: begin
        if (LOAD) begin
          state_d   = S_START;
          shift_d   = DATA;
          bit_idx_d = {BW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (tick) begin
          state_d   = S_DATA;
          bit_idx_d = {BW{1'b0}};
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == LAST_BIT) begin
            state_d   = S_STOP;
            bit_idx_d = {BW{1'b0}};
          end else begin
            bit_idx_d = bit_idx_q + BW'(1);
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_STOP: begin
        if (tick) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d   = S_IDLE;
        shift_d   = {WIDTH{1'b0}};
        bit_idx_d = {BW{1'b0}};
      end
    endcase
  end

  // Output values for the coming cycle, derived from the state being entered.
  always_comb begin
    case (state_d)
      S_IDLE:  sout_d = LINE_IDLE;
      S_START: sout_d = START_LVL;
      S_DATA:  sout_d = shift_d[0];
      S_STOP:  sout_d = STOP_LVL;
      default: sout_d = LINE_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_STOP) && tick_next;
  end

  // FSM and output registers; reset abandons any frame and idles the line.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      shift_q   <= {WIDTH{1'b0}};
      bit_idx_q <= {BW{1'b0}};
      sout_q    <= LINE_IDLE;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      sout_q    <= sout_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign SOUT  = sout_q;
  assign READY = ready_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx. Expected per-cycle outputs
// {SOUT, DONE, BUSY, READY} are queued from a frame model at the capture edge
// and popped and compared on each falling edge.
module tb_serial_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic       load;
  logic [7:0] data1;
  logic       load1;
  logic       ready, sout, busy, done;
  logic       ready1, sout1, busy1, done1;
  logic [3:0] obs;
  logic [3:0] obs1;
  logic [3:0] exp_q[$];
  logic [3:0] e;
  int         total = 0;
  int         bad = 0;

  localparam logic [3:0] IDLE_OBS = 4'b1001;

  always #5 clk = ~clk;

  serial_tx #(.WIDTH(8), .DIV(4)) dut (
    .CLK(clk), .RST(rst_n), .DATA(data), .LOAD(load),
    .READY(ready), .SOUT(sout), .BUSY(busy), .DONE(done)
  );

  serial_tx #(.WIDTH(8), .DIV(1)) dut1 (
    .CLK(clk), .RST(rst_n), .DATA(data1), .LOAD(load1),
    .READY(ready1), .SOUT(sout1), .BUSY(busy1), .DONE(done1)
  );

  assign obs  = {sout, done, busy, ready};
  assign obs1 = {sout1, done1, busy1, ready1};

  // Model of one frame, one entry per cycle after the capture edge.
  task automatic push_frame(input logic [7:0] d, input int div);
    for (int k = 1; k <= 10 * div; k++) begin
      int   b;
      logic s;
      b = (k - 1) / div;
      if (b == 0) s = 1'b0;
      else if (b <= 8) s = d[b-1];
      else s = 1'b1;
      exp_q.push_back({s, (k == 10 * div), 1'b1, 1'b0});
    end
  endtask

  // Drive a one-cycle LOAD request into the DIV=4 instance, return after the capture edge.
  task automatic start_frame(input logic [7:0] d);
    @(negedge clk);
    data = d;
    load = 1'b1;
    @(posedge clk);
    push_frame(d, 4);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (obs !== IDLE_OBS) begin
        bad++;
        $display("FAIL reset div4 cyc=%0d got=%b want=%b", i, obs, IDLE_OBS);
      end
      total++;
      if (obs1 !== IDLE_OBS) begin
        bad++;
        $display("FAIL reset div1 cyc=%0d got=%b want=%b", i, obs1, IDLE_OBS);
      end
      data  = 8'($urandom);
      load  = 1'($urandom_range(0, 1));
      data1 = 8'($urandom);
      load1 = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    load  = 1'b0;
    load1 = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_single_frame();
    start_frame(8'hA5);
    exp_q.push_back(IDLE_OBS);
    for (int i = 1; i <= 41; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL single_frame cyc=%0d got=%b want=%b", i, obs, e);
      end
      if (i == 1) load = 1'b0;
    end
  endtask

  task automatic test_load_during_frame();
    start_frame(8'h3C);
    for (int i = 0; i < 6; i++) exp_q.push_back(IDLE_OBS);
    for (int i = 1; i <= 46; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL load_during_frame cyc=%0d got=%b want=%b", i, obs, e);
      end
      if (i == 1) load = 1'b0;
      if (i == 10) begin
        load = 1'b1;
        data = 8'hFF;
      end
      if (i == 11) load = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int done_cyc[$];
    start_frame(8'h00);
    exp_q.push_back(IDLE_OBS);
    push_frame(8'hFF, 4);
    exp_q.push_back(IDLE_OBS);
    for (int i = 1; i <= 82; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL back_to_back cyc=%0d got=%b want=%b", i, obs, e);
      end
      if (done === 1'b1) done_cyc.push_back(i);
      if (i == 1) data = 8'hFF;
      if (i == 42) load = 1'b0;
    end
    total++;
    if (done_cyc.size() != 2) begin
      bad++;
      $display("FAIL back_to_back_done_count got=%0d want=2", done_cyc.size());
    end else if (done_cyc[1] - done_cyc[0] != 41) begin
      bad++;
      $display("FAIL back_to_back_done_gap got=%0d want=41", done_cyc[1] - done_cyc[0]);
    end
  endtask

  task automatic test_reset_mid_frame();
    start_frame(8'h55);
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL mid_reset_pre cyc=%0d got=%b want=%b", i, obs, e);
      end
      if (i == 1) load = 1'b0;
    end
    exp_q.delete();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (obs !== IDLE_OBS) begin
      bad++;
      $display("FAIL mid_reset_async got=%b want=%b", obs, IDLE_OBS);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (obs !== IDLE_OBS) begin
        bad++;
        $display("FAIL mid_reset_hold cyc=%0d got=%b want=%b", i, obs, IDLE_OBS);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (obs !== IDLE_OBS) begin
        bad++;
        $display("FAIL mid_reset_after cyc=%0d got=%b want=%b", i, obs, IDLE_OBS);
      end
    end
    start_frame(8'h81);
    exp_q.push_back(IDLE_OBS);
    for (int i = 1; i <= 41; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL mid_reset_reframe cyc=%0d got=%b want=%b", i, obs, e);
      end
      if (i == 1) load = 1'b0;
    end
  endtask

  task automatic test_div1();
    @(negedge clk);
    data1 = 8'h01;
    load1 = 1'b1;
    @(posedge clk);
    push_frame(8'h01, 1);
    exp_q.push_back(IDLE_OBS);
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (obs1 !== e) begin
        bad++;
        $display("FAIL div1 cyc=%0d got=%b want=%b", i, obs1, e);
      end
      if (i == 1) load1 = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    data  = 8'h00;
    load  = 1'b0;
    data1 = 8'h00;
    load1 = 1'b0;
    test_reset();
    test_single_frame();
    test_load_during_frame();
    test_back_to_back();
    test_reset_mid_frame();
    test_div1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
# serial_tx

Parallel-in, serial-out framed transmitter. It accepts a WIDTH-bit word over a valid/ready load handshake and drives it out on a single line. Each frame is a low start bit, then the data bits LSB first, then a high stop bit, with every bit held for DIV clocks. It sits downstream of the team's 8-bit enable-load register and is the serial end of that parallel data path.

## Interface
- WIDTH, 8, data word width in bits (≥1).
- DIV, 4, clocks per serial bit (≥1).

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  reset, asynchronous, active-low.
- DATA  in  WIDTH  parallel word to transmit.
- LOAD  in  1  request to transmit DATA; sampled on the rising edge of CLK.
- READY  out  1  high when a LOAD will be accepted.
- SOUT  out  1  serial line; idles high.
- BUSY  out  1  high while a frame is in progress.
- DONE  out  1  single-cycle pulse at the end of each frame's stop bit.

## Operation
- States: IDLE, START, DATA, STOP.
- Reset (RST low) takes effect immediately, regardless of CLK:
  - state goes to IDLE;
  - SOUT=1, READY=1, BUSY=0, DONE=0;
  - shift register, bit counter and period counter clear to 0.
- IDLE:
  - READY=1, BUSY=0, SOUT=1.
  - A rising edge with LOAD=1 captures DATA into the shift register and moves to START.
  - READY falls and BUSY rises on that same edge.
- START:
  - SOUT=0 for DIV cycles, then go to DATA with bit index 0.
- DATA:
  - SOUT = shift register bit 0.
  - After DIV cycles, shift right by one and increment the bit index.
  - After bit WIDTH-1 completes, go to STOP.
- STOP:
  - SOUT=1 for DIV cycles.
  - On the last cycle of STOP, DONE=1 for exactly that one cycle.
  - The following edge returns to IDLE (READY=1, BUSY=0).
- LOAD while READY=0 is ignored. It is not queued, and DATA changes mid-frame have no effect.
- Back-to-back frames:
  - LOAD held high continuously starts the next frame on the first IDLE cycle.
  - This gives exactly one idle-high cycle between the stop bit and the next start bit.
- Period counter:
  - width max(1, $clog2(DIV));
  - counts 0..DIV-1, wraps to 0 on each bit boundary.
- Bit index:
  - width max(1, $clog2(WIDTH));
  - never exceeds WIDTH-1.
- DIV=1: each bit lasts one cycle; no special casing in behaviour.
- Reset mid-frame abandons the frame. No DONE is produced and the line returns high immediately.

## Timing
- Capture edge = T0. Start bit occupies cycles T0+1 .. T0+DIV.
- Data bit k occupies T0+1+(k+1)·DIV .. T0+(k+2)·DIV.
- Stop bit occupies T0+1+(WIDTH+1)·DIV .. T0+(WIDTH+2)·DIV.
- DONE is high in cycle T0+(WIDTH+2)·DIV. READY returns at the edge ending that cycle.
- Frame length is (WIDTH+2)·DIV cycles from the first start-bit cycle.
- SOUT, READY, BUSY and DONE are all registered outputs, with no combinational path from inputs.

## Structure
- Shared package serial_pkg holds:
  - the state enum (IDLE, START, DATA, STOP);
  - LINE_IDLE=1'b1, START_LVL=1'b0, STOP_LVL=1'b1.
  - A future serial_rx reuses this package.
- One sub-module, bit_timer:
  - parameter DIV; inputs CLK, RST, clr;
  - output tick, high on the last cycle of each bit period.
- serial_tx holds the FSM, shift register and bit index.

## Test plan
1. Reset: hold RST low for 3 cycles with random inputs. Required: SOUT=1, READY=1, BUSY=0, DONE=0. Assert RST low mid-cycle and check the outputs change before the next CLK edge.
2. Single frame, WIDTH=8, DIV=4, DATA=8'hA5, LOAD pulsed one cycle.
   - Required SOUT, 4 cycles per bit: 0, 1,0,1,0,0,1,0,1, 1.
   - DONE high in cycle 40 after capture; READY high again at cycle 41.
3. LOAD during frame: send 8'h3C, then pulse LOAD with DATA=8'hFF at cycle 10. Required: the frame carries 8'h3C unaltered, and no second frame follows.
4. Back-to-back: LOAD held high with DATA=8'h00 then 8'hFF. Required: two frames, exactly 1 idle-high cycle between them, and two DONE pulses 41 cycles apart.
5. Reset mid-frame: drop RST during data bit 3 of 8'h55. Required: SOUT=1 immediately and no DONE. After release, a new LOAD of 8'h81 produces a correct full frame.
6. DIV=1, WIDTH=8, DATA=8'h01. Required: SOUT sequence 0,1,0,0,0,0,0,0,0,1 on consecutive cycles, and DONE in cycle 10 after capture.
